// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings, state/ALU/immediate enums and the immediate
// extraction helper for the mc_cpu_core multi-cycle RV32I-subset core.
package mc_pkg;

  // Major opcodes
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // funct7 values
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // funct3 values
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;

  localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASSB, ALU_MUL
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_fmt_t;

  // Instruction class: selects the path out of EXEC
  typedef enum logic [2:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_HALT
  } cls_t;

  // 32-bit sign-extended immediate for the given format
  function automatic logic [31:0] imm_extract(input logic [31:0] instr, input imm_fmt_t fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'h0000_0000;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// mc_regfile: NREGS x XLEN register file, two combinational read ports,
// one synchronous write port, x0 hardwired to zero, synchronous clear.
// Index bits above $clog2(NREGS) are ignored.
module mc_regfile
  import mc_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  input  logic [4:0]      wa,
  input  logic            we,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  localparam int RW = $clog2(NREGS);

  logic [XLEN-1:0] regs_r [NREGS];
  logic [RW-1:0]   ia1_s, ia2_s, iw_s;

  assign ia1_s = ra1[RW-1:0];
  assign ia2_s = ra2[RW-1:0];
  assign iw_s  = wa[RW-1:0];

  // Read ports: x0 always reads as zero
  always_comb begin
    rd1 = (ia1_s == '0) ? '0 : regs_r[ia1_s];
    rd2 = (ia2_s == '0) ? '0 : regs_r[ia2_s];
  end

  // Clear on reset, otherwise write any register except x0
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_r[i] <= '0;
    end else if (we && (iw_s != '0)) begin
      regs_r[iw_s] <= wd;
    end
  end

endmodule

// File: rtl/mc_cpu_core.sv
// mc_cpu_core: multi-cycle RV32I-subset processor with internal instruction
// and data memories, an auto-incrementing loader, halt/illegal reporting and
// a retired-instruction counter.
// Optional feature: define MC_MUL_EN to enable MUL with a MUL_CYCLES-long EXEC.
module mc_cpu_core
  import mc_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int IMEM_DEPTH = 128,
  parameter int DMEM_DEPTH = 256,
  parameter int NREGS      = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [31:0]                   load_data,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          illegal,
  output logic [$clog2(IMEM_DEPTH)-1:0] pc,
  output logic [XLEN-1:0]               result,
  output logic [31:0]                   retired
);

  localparam int PCW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);
  localparam int SHW = $clog2(XLEN);

  state_t          state_r, state_nx_s;
  logic [PCW-1:0]  load_ptr_r, pc_r;
  logic [31:0]     imem_r [IMEM_DEPTH];
  logic [XLEN-1:0] dmem_r [DMEM_DEPTH];
  logic [31:0]     instr_r;
  logic [XLEN-1:0] op_a_r, op_b_r, imm_r, alu_r, mem_r, result_r;
  logic            busy_r, done_r, illegal_r;
  logic [31:0]     retired_r;

  // Decode fields and decoded controls
  logic [6:0]      opcode_s, f7_s;
  logic [4:0]      rd_s, rs1_s, rs2_s;
  logic [2:0]      f3_s;
  cls_t            dec_cls_s;
  alu_op_t         dec_alu_s;
  imm_fmt_t        dec_fmt_s;
  logic            dec_use_imm_s, dec_illegal_s;
  logic [31:0]     imm32_s;
  logic [XLEN-1:0] imm_ext_s, rf_rd1_s, rf_rd2_s, wb_data_s;

  // Execute / sequencing
  logic [XLEN-1:0]        alu_b_s, alu_y_s, link_s;
  logic signed [XLEN-1:0] alu_a_sgn_s, alu_b_sgn_s;
  logic [SHW-1:0]         shamt_s;
  logic [PCW-1:0]         pc_inc_s, pc_tgt_s, pc_nx_s;
  logic [DAW-1:0]         daddr_s;
  logic                   take_s, retire_s, mul_wait_s, start_ok_s, load_ok_s;

  assign opcode_s = instr_r[6:0];
  assign rd_s     = instr_r[11:7];
  assign f3_s     = instr_r[14:12];
  assign rs1_s    = instr_r[19:15];
  assign rs2_s    = instr_r[24:20];
  assign f7_s     = instr_r[31:25];

  assign start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_HALT));
  assign load_ok_s  = load && !busy_r;

  // Instruction decode: anything not matched lands in CLS_HALT
  always_comb begin
    dec_cls_s     = CLS_HALT;
    dec_alu_s     = ALU_ADD;
    dec_fmt_s     = IMM_NONE;
    dec_use_imm_s = 1'b0;
    case (opcode_s)
      OP_RTYPE: begin
        if (f7_s == F7_BASE) begin
          dec_cls_s = CLS_ALU;
          case (f3_s)
            F3_ADD:  dec_alu_s = ALU_ADD;
            F3_SLL:  dec_alu_s = ALU_SLL;
            F3_SLT:  dec_alu_s = ALU_SLT;
            F3_XOR:  dec_alu_s = ALU_XOR;
            F3_SR:   dec_alu_s = ALU_SRL;
            F3_OR:   dec_alu_s = ALU_OR;
            F3_AND:  dec_alu_s = ALU_AND;
            default: dec_cls_s = CLS_HALT;
          endcase
        end else if ((f7_s == F7_ALT) && (f3_s == F3_ADD)) begin
          dec_cls_s = CLS_ALU;
          dec_alu_s = ALU_SUB;
        end else if ((f7_s == F7_ALT) && (f3_s == F3_SR)) begin
          dec_cls_s = CLS_ALU;
          dec_alu_s = ALU_SRA;
`ifdef MC_MUL_EN
        end else if ((f7_s == F7_MULDIV) && (f3_s == F3_ADD)) begin
          dec_cls_s = CLS_ALU;
          dec_alu_s = ALU_MUL;
`endif
        end else begin
          dec_cls_s = CLS_HALT;
        end
      end
      OP_ITYPE: begin
        dec_cls_s     = CLS_ALU;
        dec_fmt_s     = IMM_I;
        dec_use_imm_s = 1'b1;
        case (f3_s)
          F3_ADD:  dec_alu_s = ALU_ADD;
          F3_SLT:  dec_alu_s = ALU_SLT;
          F3_XOR:  dec_alu_s = ALU_XOR;
          F3_OR:   dec_alu_s = ALU_OR;
          F3_AND:  dec_alu_s = ALU_AND;
          default: dec_cls_s = CLS_HALT;
        endcase
      end
      OP_LUI: begin
        dec_cls_s     = CLS_ALU;
        dec_alu_s     = ALU_PASSB;
        dec_fmt_s     = IMM_U;
        dec_use_imm_s = 1'b1;
      end
      OP_LOAD: begin
        dec_fmt_s     = IMM_I;
        dec_use_imm_s = 1'b1;
        dec_cls_s     = (f3_s == F3_LW) ? CLS_LOAD : CLS_HALT;
      end
      OP_STORE: begin
        dec_fmt_s     = IMM_S;
        dec_use_imm_s = 1'b1;
        dec_cls_s     = (f3_s == F3_LW) ? CLS_STORE : CLS_HALT;
      end
      OP_BRANCH: begin
        dec_fmt_s = IMM_B;
        dec_cls_s = ((f3_s == F3_BEQ) || (f3_s == F3_BNE)) ? CLS_BRANCH : CLS_HALT;
      end
      OP_JAL: begin
        dec_fmt_s = IMM_J;
        dec_cls_s = CLS_JAL;
      end
      default: dec_cls_s = CLS_HALT;
    endcase
  end

  assign dec_illegal_s = (dec_cls_s == CLS_HALT) && (instr_r != ECALL_WORD);
  assign imm32_s       = imm_extract(instr_r, dec_fmt_s);
  assign imm_ext_s     = XLEN'($signed(imm32_s));

  mc_regfile #(.NREGS(NREGS), .XLEN(XLEN)) u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1_s),
    .ra2 (rs2_s),
    .wa  (rd_s),
    .we  (state_r == ST_WB),
    .wd  (wb_data_s),
    .rd1 (rf_rd1_s),
    .rd2 (rf_rd2_s)
  );

  // ALU on the registered operands
  always_comb begin
    alu_b_s     = dec_use_imm_s ? imm_r : op_b_r;
    alu_a_sgn_s = op_a_r;
    alu_b_sgn_s = alu_b_s;
    shamt_s     = alu_b_s[SHW-1:0];
    case (dec_alu_s)
      ALU_ADD:   alu_y_s = op_a_r + alu_b_s;
      ALU_SUB:   alu_y_s = op_a_r - alu_b_s;
      ALU_AND:   alu_y_s = op_a_r & alu_b_s;
      ALU_OR:    alu_y_s = op_a_r | alu_b_s;
      ALU_XOR:   alu_y_s = op_a_r ^ alu_b_s;
      ALU_SLT:   alu_y_s = (alu_a_sgn_s < alu_b_sgn_s) ? XLEN'(1'b1) : '0;
      ALU_SLL:   alu_y_s = op_a_r << shamt_s;
      ALU_SRL:   alu_y_s = op_a_r >> shamt_s;
      ALU_SRA:   alu_y_s = alu_a_sgn_s >>> shamt_s;
      ALU_PASSB: alu_y_s = alu_b_s;
`ifdef MC_MUL_EN
      ALU_MUL:   alu_y_s = op_a_r * alu_b_s;
`endif
      default:   alu_y_s = op_a_r + alu_b_s;
    endcase
  end

  assign pc_inc_s  = pc_r + PCW'(1'b1);
  assign pc_tgt_s  = pc_r + imm_r[PCW+1:2];
  assign link_s    = XLEN'({pc_inc_s, 2'b00});
  assign take_s    = (f3_s == F3_BNE) ? (op_a_r != op_b_r) : (op_a_r == op_b_r);
  assign daddr_s   = alu_r[DAW+1:2];
  assign wb_data_s = (dec_cls_s == CLS_LOAD) ? mem_r : alu_r;

`ifdef MC_MUL_EN
  localparam int MCW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  logic [MCW-1:0] mul_cnt_r;

  // Load the extra EXEC occupancy while decoding, then count it down in EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_cnt_r <= '0;
    end else if (state_r == ST_DECODE) begin
      mul_cnt_r <= MCW'(MUL_CYCLES - 1);
    end else if ((state_r == ST_EXEC) && (mul_cnt_r != '0)) begin
      mul_cnt_r <= mul_cnt_r - MCW'(1'b1);
    end
  end

  assign mul_wait_s = (dec_alu_s == ALU_MUL) && (mul_cnt_r != '0);
`else
  assign mul_wait_s = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE, ST_HALT: state_nx_s = start ? ST_FETCH : state_r;
      ST_FETCH:         state_nx_s = ST_DECODE;
      ST_DECODE:        state_nx_s = ST_EXEC;
      ST_EXEC: begin
        if (mul_wait_s) begin
          state_nx_s = ST_EXEC;
        end else begin
          case (dec_cls_s)
            CLS_ALU, CLS_JAL:    state_nx_s = ST_WB;
            CLS_LOAD, CLS_STORE: state_nx_s = ST_MEM;
            CLS_BRANCH:          state_nx_s = ST_FETCH;
            default:             state_nx_s = ST_HALT;
          endcase
        end
      end
      ST_MEM:           state_nx_s = (dec_cls_s == CLS_LOAD) ? ST_WB : ST_FETCH;
      ST_WB:            state_nx_s = ST_FETCH;
      default:          state_nx_s = ST_IDLE;
    endcase
  end

  // Retirement and next pc, evaluated in the last cycle of each instruction
  always_comb begin
    retire_s = 1'b0;
    pc_nx_s  = pc_r;
    case (state_r)
      ST_EXEC: begin
        if (dec_cls_s == CLS_BRANCH) begin
          retire_s = 1'b1;
          pc_nx_s  = take_s ? pc_tgt_s : pc_inc_s;
        end else begin
          retire_s = 1'b0;
          pc_nx_s  = pc_r;
        end
      end
      ST_MEM: begin
        if (dec_cls_s == CLS_STORE) begin
          retire_s = 1'b1;
          pc_nx_s  = pc_inc_s;
        end else begin
          retire_s = 1'b0;
          pc_nx_s  = pc_r;
        end
      end
      ST_WB: begin
        retire_s = 1'b1;
        pc_nx_s  = (dec_cls_s == CLS_JAL) ? pc_tgt_s : pc_inc_s;
      end
      default: begin
        retire_s = 1'b0;
        pc_nx_s  = pc_r;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nx_s;
  end

  // Registered status outputs, pc, result, retired count and loader pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      illegal_r  <= 1'b0;
      pc_r       <= '0;
      result_r   <= '0;
      retired_r  <= 32'd0;
      load_ptr_r <= '0;
    end else begin
      busy_r <= (state_nx_s != ST_IDLE) && (state_nx_s != ST_HALT);
      if (load_ok_s) load_ptr_r <= load_ptr_r + PCW'(1'b1);
      if (start_ok_s) begin
        pc_r      <= '0;
        done_r    <= 1'b0;
        illegal_r <= 1'b0;
      end else begin
        pc_r <= pc_nx_s;
        if ((state_r == ST_EXEC) && (state_nx_s == ST_HALT)) begin
          done_r    <= 1'b1;
          illegal_r <= dec_illegal_s;
        end
      end
      if (state_r == ST_WB) result_r <= wb_data_s;
      if (retire_s) retired_r <= retired_r + 32'd1;
    end
  end

  // Pipeline registers: fetched word, decoded operands, ALU result
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_r <= 32'h0000_0000;
      op_a_r  <= '0;
      op_b_r  <= '0;
      imm_r   <= '0;
      alu_r   <= '0;
    end else begin
      if (state_r == ST_FETCH) instr_r <= imem_r[pc_r];
      if (state_r == ST_DECODE) begin
        op_a_r <= rf_rd1_s;
        op_b_r <= rf_rd2_s;
        imm_r  <= imm_ext_s;
      end
      if (state_r == ST_EXEC) alu_r <= (dec_cls_s == CLS_JAL) ? link_s : alu_y_s;
    end
  end

  // Instruction memory loader port
  always_ff @(posedge clk) begin
    if (!rst && load_ok_s) imem_r[load_ptr_r] <= load_data;
  end

  // Data memory: store write and registered load read in MEM; a reset drops the store
  always_ff @(posedge clk) begin
    if (!rst && (state_r == ST_MEM) && (dec_cls_s == CLS_STORE)) dmem_r[daddr_s] <= op_b_r;
    if (state_r == ST_MEM) mem_r <= dmem_r[daddr_s];
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign illegal = illegal_r;
  assign pc      = pc_r;
  assign result  = result_r;
  assign retired = retired_r;

endmodule

// File: doc/mc_cpu_core.md
# mc_cpu_core

Parametrised multi-cycle RV32I-subset core: the next generation of the team's multi-cycle CPU top. It adds:

- configurable memory depths and register count;
- a loader with an auto-incrementing pointer;
- explicit halt/illegal reporting;
- a retired-instruction counter;
- an optional multi-cycle multiplier.

Instruction and data memories are internal. The block is the whole processor under the test harness.

## Interface
- XLEN, 32: datapath width, ≥32; immediates sign-extended to XLEN.
- IMEM_DEPTH, 128: instruction words, power of 2; PCW = $clog2(IMEM_DEPTH).
- DMEM_DEPTH, 256: data words, power of 2; DAW = $clog2(DMEM_DEPTH).
- NREGS, 32: architectural registers, 16 or 32; register-index bits above $clog2(NREGS) are ignored.
- MUL_CYCLES, 4: EXEC occupancy for MUL, ≥1.

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- load  in  1  write load_data to imem[load_ptr], then increment load_ptr
- load_data  in  32  instruction word
- start  in  1  begin execution at pc 0
- busy  out  1  state ∉ {IDLE, HALT}
- done  out  1  halted on ECALL or illegal instruction
- illegal  out  1  halt cause was an undecodable instruction
- pc  out  PCW  word-addressed program counter
- result  out  XLEN  last value written to the register file
- retired  out  32  completed-instruction count

## Operation
- Supported instructions:
  - R-type: ADD, SUB, AND, OR, XOR, SLT, SLL, SRL, SRA.
  - I-type: ADDI, ANDI, ORI, XORI, SLTI.
  - Other: LUI, LW, SW, BEQ, BNE, JAL, ECALL (0x00000073).
- Any other encoding is illegal.
- Loader:
  - load is accepted only when busy=0.
  - load_ptr wraps modulo IMEM_DEPTH.
  - load_ptr resets to 0 on rst and is not reset by start.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Transitions:
  - IDLE/HALT –start→ FETCH. pc, done and illegal are cleared. Registers and dmem are retained.
  - FETCH→DECODE: registered synchronous imem read.
  - DECODE→EXEC: register-file read; operands registered.
  - EXEC →
    - MEM for LW and SW;
    - WB for ALU ops, LUI and JAL;
    - FETCH for BEQ/BNE;
    - HALT for ECALL or illegal.
  - MEM → WB for LW; MEM → FETCH for SW.
  - WB → FETCH.
- x0 reads 0; writes to x0 are discarded. result still shows the discarded value.
- pc arithmetic:
  - pc+1 modulo IMEM_DEPTH.
  - Branch/JAL target = pc + (imm >>> 2), modulo IMEM_DEPTH.
  - JAL writes rd = (pc+1)<<2.
- Data address = ALU result[DAW+1:2]. Low 2 bits and bits above DAW+1 are ignored; there is no fault.
- SLL/SRL/SRA shift amount = operand2[$clog2(XLEN)-1:0].
- retired:
  - +1 at the last cycle of every non-ECALL, non-illegal instruction.
  - Wraps at 2^32.
  - Cleared only by rst.
- start while busy=1 is ignored; load while busy=1 is ignored.

## Timing
- Reset values:
  - busy 0, done 0, illegal 0, pc 0, result 0, retired 0.
  - State IDLE; load_ptr 0. Register file cleared to 0. dmem is not reset.
- Cycles per instruction:
  - ALU, LUI, JAL: 4.
  - LW: 5.
  - SW: 4.
  - BEQ/BNE: 3, taken or not.
  - ECALL/illegal: 3, then HALT.
- State changes on the clock edge. busy rises the cycle after start is sampled.
- done and illegal assert on entry to HALT and hold until start or rst.
- rst mid-instruction:
  - Next cycle is IDLE with every output at its reset value.
  - An in-flight SW is lost if rst is high in its MEM cycle.
- load and start in the same cycle while idle: the load is written and execution starts. The new word is fetchable.

## Configuration
- MC_MUL_EN defined:
  - MUL (opcode 0110011, funct7 0000001, funct3 000) is legal.
  - Writes the low XLEN bits of the product.
  - EXEC lasts MUL_CYCLES cycles via an internal down-counter; WB follows.
- MC_MUL_EN undefined: that encoding is illegal and halts with illegal=1. The counter logic is absent.

## Structure
- Package mc_pkg holds:
  - opcode/funct constants;
  - state enum;
  - ALU-op enum;
  - ECALL constant;
  - immediate-format enum.
- Sub-module mc_regfile, parametrised by NREGS and XLEN:
  - two combinational read ports, one synchronous write port;
  - x0 hardwired to zero;
  - synchronous clear on rst.
- Memories, decode, FSM and ALU live in mc_cpu_core.

## Test plan
- Load `ADDI x1,x0,5`; `ADDI x2,x0,-3`; `ADD x3,x1,x2`; ECALL. Start.
  - Expect result=2 and done=1 with illegal=0.
  - Expect retired=3 and 15 cycles from busy↑ to done↑.
- Load `ADDI x1,x0,0x44`; `SW x1,8(x0)`; `LW x4,8(x0)`; ECALL.
  - Expect result=0x44 and x4=0x44.
- Branch loop: `ADDI x1,x0,3`; `ADDI x1,x1,-1`; `BNE x1,x0,-4`; ECALL.
  - Expect retired=7 and result=0.
- Illegal word 0xFFFFFFFF at pc 0, then start.
  - Expect done=1 and illegal=1 after 3 cycles; pc=0; retired=0.
- rst asserted in the EXEC cycle of ADD.
  - Next cycle: busy=0, result=0, retired=0.
  - A following 129th load writes imem[0] (pointer wrap).
- Under MC_MUL_EN: `ADDI x1,x0,7`; `ADDI x2,x0,6`; `MUL x3,x1,x2`.
  - Expect result=42; MUL takes 3+MUL_CYCLES cycles.
  - Without MC_MUL_EN the MUL halts with illegal=1.
